spi_diff_slave_phy: RTL and testbench

Standalone SPI slave endpoint for the differential SPI link: receives differential SCLK/CS/MOSI pairs from the on-board differential master, shifts in a DATA_W-bit word and simultaneously returns a preloaded word on differential MISO. It oversamples the link in the local `clk` domain, so it works with an asynchronous remote master. It is the far-end counterpart the link master talks to when the slave sits on a separate board or clock domain.

---
 rtl/spi_diff_pkg.sv | 21 ++
 rtl/spi_diff_sync_rx.sv | 42 ++++
 rtl/spi_diff_slave_phy.sv | 136 +++++++++++++
 tb/tb_spi_diff_slave_phy.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_diff_pkg.sv
// Shared types and defaults for the differential SPI link (slave PHY and link master).
package spi_diff_pkg;

  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_WAIT_END = 2'd0,
    ST_IDLE     = 2'd1,
    ST_SHIFT    = 2'd2
  } state_e;

  // Decoded status of one synchronized differential pair
  typedef struct packed {
    logic value;
    logic fault;
    logic rise;
    logic fall;
  } pair_s;

endpackage

// File: rtl/spi_diff_sync_rx.sv
// Synchronizes one differential p/n pair into clk and decodes value, fault and edges.
module spi_diff_sync_rx
  import spi_diff_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_p,
  input  logic  i_n,
  output pair_s o_pair_c
);

  logic [SYNC_STAGES-1:0] r_p_sync;
  logic [SYNC_STAGES-1:0] r_n_sync;
  logic                   r_prev;
  logic                   w_p;
  logic                   w_n;

  assign w_p = r_p_sync[SYNC_STAGES-1];
  assign w_n = r_n_sync[SYNC_STAGES-1];

  // Reset to a valid, non-faulted line state at RST_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_sync <= {SYNC_STAGES{RST_VAL}};
      r_n_sync <= {SYNC_STAGES{~RST_VAL}};
      r_prev   <= RST_VAL;
    end else begin
      r_p_sync <= {r_p_sync[SYNC_STAGES-2:0], i_p};
      r_n_sync <= {r_n_sync[SYNC_STAGES-2:0], i_n};
      r_prev   <= w_p;
    end
  end

  assign o_pair_c.value = w_p;
  assign o_pair_c.fault = (w_p == w_n);
  assign o_pair_c.rise  = w_p & ~r_prev;
  assign o_pair_c.fall  = ~w_p & r_prev;

endmodule

// File: rtl/spi_diff_slave_phy.sv
// Oversampling SPI mode-0 slave on differential pairs: shifts in a word, returns a preloaded word.
module spi_diff_slave_phy
  import spi_diff_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_p,
  input  logic              sclk_n,
  input  logic              csn_p,
  input  logic              csn_n,
  input  logic              mosi_p,
  input  logic              mosi_n,
  output logic              miso_p,
  output logic              miso_n,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  pair_s w_sclk;
  pair_s w_csn;
  pair_s w_mosi;
  logic  w_any_fault;
  logic  w_unused;

  state_e              r_state;
  logic [DATA_W-2:0]   r_tx_sr;
  logic [DATA_W-2:0]   r_rx_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_miso;
  logic                r_tx_ready;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_frame_err;

  spi_diff_sync_rx #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_p(sclk_p), .i_n(sclk_n), .o_pair_c(w_sclk)
  );

  spi_diff_sync_rx #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst_n(rst_n), .i_p(csn_p), .i_n(csn_n), .o_pair_c(w_csn)
  );

  spi_diff_sync_rx #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_p(mosi_p), .i_n(mosi_n), .o_pair_c(w_mosi)
  );

  assign w_any_fault = w_sclk.fault | w_csn.fault | w_mosi.fault;
  assign w_unused    = ^{w_sclk.value, w_mosi.rise, w_mosi.fall};

  // Frame FSM; tx/rx shift registers hold DATA_W-1 bits since the MSB lives in r_miso / is taken from mosi
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT_END;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_cnt       <= '0;
      r_miso      <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_WAIT_END: begin
          r_miso <= 1'b0;
          if (w_csn.value && !w_any_fault) begin
            r_state    <= ST_IDLE;
            r_tx_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          r_miso <= 1'b0;
          if (w_any_fault) begin
            r_state    <= ST_WAIT_END;
            r_tx_ready <= 1'b0;
          end else if (w_csn.fall) begin
            r_tx_sr    <= tx_data[DATA_W-2:0];
            r_miso     <= tx_data[DATA_W-1];
            r_cnt      <= '0;
            r_state    <= ST_SHIFT;
            r_tx_ready <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_any_fault) begin
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
            r_state     <= ST_WAIT_END;
          end else if (w_csn.rise) begin
            // CSN wins over a coincident SCLK edge
            r_frame_err <= (r_cnt != CNT_W'(DATA_W));
            r_miso      <= 1'b0;
            r_state     <= ST_IDLE;
            r_tx_ready  <= 1'b1;
          end else if (r_cnt != CNT_W'(DATA_W)) begin
            if (w_sclk.rise) begin
              r_rx_sr <= {r_rx_sr[DATA_W-3:0], w_mosi.value};
              r_cnt   <= CNT_W'(r_cnt + 1'b1);
              if (r_cnt == CNT_W'(DATA_W - 1)) begin
                r_rx_data  <= {r_rx_sr, w_mosi.value};
                r_rx_valid <= 1'b1;
                r_miso     <= 1'b0;
              end
            end else if (w_sclk.fall) begin
              r_miso  <= r_tx_sr[DATA_W-2];
              r_tx_sr <= {r_tx_sr[DATA_W-3:0], 1'b0};
            end
          end
        end
        default: begin
          r_state    <= ST_WAIT_END;
          r_miso     <= 1'b0;
          r_tx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign miso_p    = r_miso;
  assign miso_n    = ~r_miso;
  assign tx_ready  = r_tx_ready;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_diff_slave_phy.sv
// Self-checking bench for spi_diff_slave_phy: behaves as an SPI mode-0 master over differential pairs.
module tb_spi_diff_slave_phy;

  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              sclk_p, sclk_n, csn_p, csn_n, mosi_p, mosi_n;
  logic              miso_p, miso_n;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;

  int          n_tests;
  int          n_fail;
  int          valid_cnt;
  int          err_cnt;
  int          miso_bad;
  int          hp;
  logic [31:0] exp_rx;

  spi_diff_slave_phy #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .sclk_p(sclk_p), .sclk_n(sclk_n),
    .csn_p(csn_p), .csn_n(csn_n),
    .mosi_p(mosi_p), .mosi_n(mosi_n),
    .miso_p(miso_p), .miso_n(miso_n),
    .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and MISO pair consistency, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if (miso_n !== ~miso_p) miso_bad <= miso_bad + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_csn(input logic deasserted);
    csn_p = deasserted;
    csn_n = ~deasserted;
  endtask

  task automatic clear_counts();
    wait_clk(1);
    valid_cnt = 0;
    err_cnt   = 0;
  endtask

  // One SCLK period: drive MOSI while low, sample MISO just before the rising edge
  task automatic sclk_bit(input logic b, output logic m);
    mosi_p = b;
    mosi_n = ~b;
    wait_clk(hp);
    m = miso_p;
    sclk_p = 1'b1;
    sclk_n = 1'b0;
    wait_clk(hp);
    sclk_p = 1'b0;
    sclk_n = 1'b1;
  endtask

  // Full CSN-framed transfer of nbits; tx_data is scrambled right after CSN falls
  task automatic run_frame(input logic [31:0] txw, input logic [31:0] rxw, input int nbits,
                           output logic [63:0] cap);
    logic m;
    logic b;
    cap = '0;
    tx_data = txw;
    set_csn(1'b0);
    wait_clk(hp);
    tx_data = $urandom;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 32) ? rxw[31-i] : 1'($urandom_range(0, 1));
      sclk_bit(b, m);
      cap[i] = m;
    end
    wait_clk(hp);
    set_csn(1'b1);
    wait_clk(hp + 6);
  endtask

  // Reference: master sees tx word MSB first, then zeros once the frame is full
  function automatic logic [63:0] exp_miso(input logic [31:0] txw, input int nbits);
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < nbits; i++) e[i] = (i < 32) ? txw[31-i] : 1'b0;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    n_tests++; if (miso_p !== 1'b0) begin n_fail++; $display("FAIL reset_miso_p got=%b exp=0", miso_p); end
    n_tests++; if (miso_n !== 1'b1) begin n_fail++; $display("FAIL reset_miso_n got=%b exp=1", miso_n); end
    n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready); end
    n_tests++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=0", rx_data); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    rst_n = 1'b1;
    wait_clk(6);
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_to_idle tx_ready got=%b exp=1", tx_ready); end
    exp_rx = 32'h0;
  endtask

  task automatic test_basic();
    logic [63:0] cap;
    hp = 8;
    clear_counts();
    run_frame(32'h3C3C_1234, 32'hA5A5_A5A5, 32, cap);
    exp_rx = 32'hA5A5_A5A5;
    n_tests++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL basic_valid_pulses got=%0d exp=1", valid_cnt); end
    n_tests++; if (rx_data !== exp_rx) begin n_fail++; $display("FAIL basic_rx_data got=%h exp=%h", rx_data, exp_rx); end
    n_tests++; if (cap !== exp_miso(32'h3C3C_1234, 32)) begin n_fail++; $display("FAIL basic_miso got=%h exp=%h", cap, exp_miso(32'h3C3C_1234, 32)); end
    n_tests++; if (err_cnt !== 0) begin n_fail++; $display("FAIL basic_frame_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] cap;
    logic [31:0] txw [2];
    logic [31:0] rxw [2];
    txw[0] = $urandom; txw[1] = $urandom;
    rxw[0] = 32'h0000_0001; rxw[1] = 32'hFFFF_FFFE;
    clear_counts();
    for (int f = 0; f < 2; f++) begin
      n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_tx_ready[%0d] got=%b exp=1", f, tx_ready); end
      run_frame(txw[f], rxw[f], 32, cap);
      n_tests++; if (rx_data !== rxw[f]) begin n_fail++; $display("FAIL b2b_rx_data[%0d] got=%h exp=%h", f, rx_data, rxw[f]); end
      n_tests++; if (cap !== exp_miso(txw[f], 32)) begin n_fail++; $display("FAIL b2b_miso[%0d] got=%h exp=%h", f, cap, exp_miso(txw[f], 32)); end
    end
    exp_rx = rxw[1];
    n_tests++; if (valid_cnt !== 2) begin n_fail++; $display("FAIL b2b_valid_pulses got=%0d exp=2", valid_cnt); end
  endtask

  task automatic test_abort();
    logic [63:0] cap;
    logic [31:0] txw;
    clear_counts();
    run_frame($urandom, $urandom, 17, cap);
    n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL abort_frame_err got=%0d exp=1", err_cnt); end
    n_tests++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL abort_valid got=%0d exp=0", valid_cnt); end
    n_tests++; if (rx_data !== exp_rx) begin n_fail++; $display("FAIL abort_rx_kept got=%h exp=%h", rx_data, exp_rx); end
    clear_counts();
    txw = $urandom;
    run_frame(txw, 32'hDEAD_BEEF, 32, cap);
    exp_rx = 32'hDEAD_BEEF;
    n_tests++; if (rx_data !== exp_rx || valid_cnt !== 1) begin n_fail++; $display("FAIL abort_next_frame got=%h/%0d exp=%h/1", rx_data, valid_cnt, exp_rx); end
    n_tests++; if (cap !== exp_miso(txw, 32)) begin n_fail++; $display("FAIL abort_next_miso got=%h exp=%h", cap, exp_miso(txw, 32)); end
  endtask

  task automatic test_line_fault();
    logic [63:0] cap;
    logic m;
    clear_counts();
    tx_data = $urandom;
    set_csn(1'b0);
    wait_clk(hp);
    for (int i = 0; i < 10; i++) sclk_bit(1'($urandom_range(0, 1)), m);
    mosi_p = 1'b1;
    mosi_n = 1'b1;
    wait_clk(6);
    n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL fault_frame_err got=%0d exp=1", err_cnt); end
    n_tests++; if (miso_p !== 1'b0) begin n_fail++; $display("FAIL fault_miso got=%b exp=0", miso_p); end
    for (int i = 10; i < 32; i++) sclk_bit(1'($urandom_range(0, 1)), m);
    wait_clk(hp);
    n_tests++; if (valid_cnt !== 0 || rx_data !== exp_rx) begin n_fail++; $display("FAIL fault_no_rx got=%0d/%h exp=0/%h", valid_cnt, rx_data, exp_rx); end
    n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL fault_wait_end tx_ready got=%b exp=0", tx_ready); end
    set_csn(1'b1);
    wait_clk(hp);
    n_tests++; if (tx_ready !== 1'b1 || err_cnt !== 1) begin n_fail++; $display("FAIL fault_recover got=%b/%0d exp=1/1", tx_ready, err_cnt); end
    clear_counts();
    exp_rx = $urandom;
    run_frame(32'h0F0F_5A5A, exp_rx, 32, cap);
    n_tests++; if (rx_data !== exp_rx || valid_cnt !== 1) begin n_fail++; $display("FAIL fault_next_frame got=%h/%0d exp=%h/1", rx_data, valid_cnt, exp_rx); end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] cap;
    logic m;
    clear_counts();
    tx_data = $urandom;
    set_csn(1'b0);
    wait_clk(hp);
    for (int i = 0; i < 10; i++) sclk_bit(1'($urandom_range(0, 1)), m);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    exp_rx = 32'h0;
    for (int i = 10; i < 32; i++) sclk_bit(1'($urandom_range(0, 1)), m);
    wait_clk(hp);
    n_tests++; if (valid_cnt !== 0 || err_cnt !== 0) begin n_fail++; $display("FAIL rstmid_pulses got=%0d/%0d exp=0/0", valid_cnt, err_cnt); end
    n_tests++; if (rx_data !== exp_rx || tx_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_state got=%h/%b exp=0/0", rx_data, tx_ready); end
    set_csn(1'b1);
    wait_clk(hp);
    clear_counts();
    run_frame(32'h8421_0FED, 32'h1357_9BDF, 32, cap);
    exp_rx = 32'h1357_9BDF;
    n_tests++; if (rx_data !== exp_rx || valid_cnt !== 1) begin n_fail++; $display("FAIL rstmid_next_frame got=%h/%0d exp=%h/1", rx_data, valid_cnt, exp_rx); end
    n_tests++; if (cap !== exp_miso(32'h8421_0FED, 32)) begin n_fail++; $display("FAIL rstmid_miso got=%h exp=%h", cap, exp_miso(32'h8421_0FED, 32)); end
  endtask

  task automatic test_overrun();
    logic [63:0] cap;
    logic [31:0] txw;
    logic [31:0] rxw;
    txw = $urandom;
    rxw = $urandom;
    clear_counts();
    run_frame(txw, rxw, 40, cap);
    exp_rx = rxw;
    n_tests++; if (rx_data !== exp_rx || valid_cnt !== 1) begin n_fail++; $display("FAIL overrun_rx got=%h/%0d exp=%h/1", rx_data, valid_cnt, exp_rx); end
    n_tests++; if (cap !== exp_miso(txw, 40)) begin n_fail++; $display("FAIL overrun_miso got=%h exp=%h", cap, exp_miso(txw, 40)); end
    n_tests++; if (err_cnt !== 0) begin n_fail++; $display("FAIL overrun_frame_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_random_frames();
    logic [63:0] cap;
    logic [31:0] txw;
    logic [31:0] rxw;
    int          nbits;
    for (int k = 0; k < 10; k++) begin
      hp    = $urandom_range(6, 10);
      txw   = $urandom;
      rxw   = $urandom;
      nbits = $urandom_range(1, 40);
      if (k < 3) nbits = 32;
      clear_counts();
      run_frame(txw, rxw, nbits, cap);
      if (nbits >= 32) exp_rx = rxw;
      n_tests++;
      if (rx_data !== exp_rx || valid_cnt !== int'(nbits >= 32) || err_cnt !== int'(nbits < 32)
          || cap !== exp_miso(txw, nbits)) begin
        n_fail++;
        $display("FAIL random[%0d] nbits=%0d rx=%h/%h valid=%0d err=%0d miso=%h/%h", k, nbits,
                 rx_data, exp_rx, valid_cnt, err_cnt, cap, exp_miso(txw, nbits));
      end
    end
    hp = 8;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; valid_cnt = 0; err_cnt = 0; miso_bad = 0; hp = 8;
    exp_rx  = 32'h0;
    rst_n   = 1'b0;
    sclk_p  = 1'b0; sclk_n = 1'b1;
    csn_p   = 1'b1; csn_n  = 1'b0;
    mosi_p  = 1'b0; mosi_n = 1'b1;
    tx_data = 32'h0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_line_fault();
    test_reset_mid_frame();
    test_overrun();
    test_random_frames();
    n_tests++; if (miso_bad !== 0) begin n_fail++; $display("FAIL miso_pair_complement got=%0d exp=0", miso_bad); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
